kmap_tt_checker: RTL and testbench

Hardware truth-table sequencer and checker for the Karnaugh-map exercises. It drives every input combination {a,b,c,d} into a combinational function under test and waits a configurable settle time. It then samples the function output, builds the captured truth table and compares it bit-by-bit against an expected table. The block is the synthesizable board-level counterpart to the simulation stimulus bench: it sits between the board's start button and LEDs and the student's `top` instance.

---
 rtl/kmap_pkg.sv | 31 +++
 rtl/kmap_settle_timer.sv | 55 +++++
 rtl/kmap_tt_checker.sv | 159 +++++++++++++++
 tb/tb_kmap_tt_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// ---------------------------------------------------------------------------
// kmap_pkg
// Shared definitions for the Karnaugh-map truth-table checker:
//   - kmap_state_e : sequencer states (IDLE / DRIVE / SAMPLE / DONE)
//   - N_IN_DEFAULT / N_MINTERMS : default input count and minterm count
//   - cnt_width()  : width of a counter that must hold 0 .. n-1
// ---------------------------------------------------------------------------
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } kmap_state_e;

  localparam int N_IN_DEFAULT = 4;
  localparam int N_MINTERMS   = 2 ** N_IN_DEFAULT;

  // A counter for 0..n-1 needs clog2(n) bits, but never fewer than one so
  // that a settle time of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// ---------------------------------------------------------------------------
// kmap_settle_timer
// Counts the cycles an input vector has been held. While `enable` is high the
// counter runs from 0 to SETTLE-1; on the last count `expired` pulses for one
// cycle and the counter returns to 0, ready for the next minterm.
//
// Parameters:
//   SETTLE  : hold time in cycles (>= 1)
// Ports:
//   clk     in  : clock, rising edge
//   rst_n   in  : synchronous active-low reset
//   load    in  : restart the count from 0
//   enable  in  : count this cycle
//   expired out : one-cycle pulse on the final settle cycle
// ---------------------------------------------------------------------------
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is combinational so the FSM leaves DRIVE on exactly the
  // SETTLE-th edge after the vector was applied.
  always_comb begin
    expired = enable && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (load || expired) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kmap_tt_checker.sv
// ---------------------------------------------------------------------------
// kmap_tt_checker
// Sweeps all 2**N_IN input combinations into a combinational function under
// test, holds each for SETTLE cycles, samples f, builds the captured truth
// table and compares it against EXPECTED.
//
// Optional build macro:
//   KMAP_STOP_ON_ERR_EN : the first mismatching minterm ends the sweep.
//
// Parameters:
//   N_IN     : number of function inputs
//   SETTLE   : cycles each vector is held before sampling (>= 1)
//   EXPECTED : expected truth table, bit i = f for minterm i
// Ports:
//   clk, rst_n     : clock and synchronous active-low reset
//   start     in   : begin a sweep when not busy (level)
//   abcd      out  : current minterm index driven to the function (a = MSB)
//   f         in   : function output
//   busy      out  : sweep in progress
//   done      out  : sweep finished, held until the next start
//   pass      out  : no mismatches (valid while done)
//   captured  out  : sampled truth table
//   err_count out  : number of mismatching minterms
//   first_err out  : lowest mismatching minterm, valid with first_err_vld
// ---------------------------------------------------------------------------
module kmap_tt_checker
  import kmap_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  parameter logic [(2**N_IN)-1:0] EXPECTED = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        abcd,
  input  logic                   f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   captured,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err,
  output logic                   first_err_vld
);

  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  kmap_state_e state_q, state_d;
  logic [N_IN-1:0]      idx_q, idx_d;
  logic [(2**N_IN)-1:0] captured_q, captured_d;
  logic [N_IN:0]        err_count_q, err_count_d;
  logic [N_IN-1:0]      first_err_q, first_err_d;
  logic                 first_err_vld_q, first_err_vld_d;

  logic timer_load;
  logic timer_expired;
  logic mismatch;
  logic stop_now;

  kmap_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .enable  (state_q == DRIVE),
    .expired (timer_expired)
  );

  // Next-state and result update. Starting from IDLE or DONE clears all
  // results so a new sweep never inherits the previous table.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    captured_d      = captured_q;
    err_count_d     = err_count_q;
    first_err_d     = first_err_q;
    first_err_vld_d = first_err_vld_q;
    timer_load      = 1'b0;
    mismatch        = 1'b0;
    stop_now        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = DRIVE;
          idx_d           = '0;
          captured_d      = '0;
          err_count_d     = '0;
          first_err_d     = '0;
          first_err_vld_d = 1'b0;
          timer_load      = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        captured_d[idx_q] = f;
        mismatch = (f != EXPECTED[idx_q]);
        if (mismatch) begin
          err_count_d = err_count_q + ERR_ONE;
          if (!first_err_vld_q) begin
            first_err_d     = idx_q;
            first_err_vld_d = 1'b1;
          end
        end
`ifdef KMAP_STOP_ON_ERR_EN
        stop_now = mismatch;
`else
        stop_now = 1'b0;
`endif
        if (stop_now || (idx_q == IDX_LAST)) begin
          state_d = DONE;
        end else begin
          idx_d      = idx_q + IDX_ONE;
          state_d    = DRIVE;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      captured_q      <= '0;
      err_count_q     <= '0;
      first_err_q     <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      captured_q      <= captured_d;
      err_count_q     <= err_count_d;
      first_err_q     <= first_err_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign abcd          = idx_q;
  assign busy          = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (err_count_q == '0);
  assign captured      = captured_q;
  assign err_count     = err_count_q;
  assign first_err     = first_err_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_kmap_tt_checker.sv
// ---------------------------------------------------------------------------
// tb_kmap_tt_checker
// Directed bench for kmap_tt_checker with SETTLE=3, EXPECTED=16'hA5A5.
// The function under test is modelled here and selected by fMode.
// ---------------------------------------------------------------------------
module tb_kmap_tt_checker;

  localparam logic [15:0] EXP_TABLE = 16'hA5A5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  abcd;
  logic        f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic [3:0]  first_err;
  logic        first_err_vld;

  int totalChecks = 0;
  int badChecks   = 0;
  int fMode       = 0;
  int sweepCycles;

  kmap_tt_checker #(
    .N_IN     (4),
    .SETTLE   (3),
    .EXPECTED (EXP_TABLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abcd          (abcd),
    .f             (f),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .captured      (captured),
    .err_count     (err_count),
    .first_err     (first_err),
    .first_err_vld (first_err_vld)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test: correct table, table with minterm 5 inverted, or
  // output stuck at 0.
  always_comb begin
    f = 1'b0;
    case (fMode)
      0: f = EXP_TABLE[abcd];
      1: f = (abcd == 4'd5) ? ~EXP_TABLE[abcd] : EXP_TABLE[abcd];
      default: f = 1'b0;
    endcase
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents start for one edge (E0) and leaves it at holdLevel afterwards.
  task automatic applyStimulus(input logic holdLevel);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = holdLevel;
  endtask

  // Counts edges after E0 until done rises (bounded). Optionally pulses
  // start for one edge once abcd reaches pulseAt.
  task automatic waitDone(input int pulseAt, output int cycles);
    bit pulsed;
    pulsed = 1'b0;
    cycles = 0;
    for (int n = 0; n < 300; n++) begin
      if (!pulsed && pulseAt >= 0 && int'(abcd) == pulseAt) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else if (pulsed) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  // Bounded wait for a particular minterm on abcd.
  task automatic waitAbcd(input logic [3:0] target);
    for (int n = 0; n < 300; n++) begin
      if (abcd == target) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_abcd"},      32'(abcd),          32'd0);
    checkOutput({tag, "_busy"},      32'(busy),          32'd0);
    checkOutput({tag, "_done"},      32'(done),          32'd0);
    checkOutput({tag, "_pass"},      32'(pass),          32'd0);
    checkOutput({tag, "_captured"},  32'(captured),      32'd0);
    checkOutput({tag, "_err_count"}, 32'(err_count),     32'd0);
    checkOutput({tag, "_first_err"}, 32'(first_err),     32'd0);
    checkOutput({tag, "_first_vld"}, 32'(first_err_vld), 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;

    // Correct function: full pass, check abcd stepping at the sample edge.
    fMode = 0;
    applyStimulus(1'b0);
    checkOutput("e0_busy", 32'(busy), 32'd1);
    checkOutput("e0_abcd", 32'(abcd), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("e3_abcd", 32'(abcd), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("e4_abcd", 32'(abcd), 32'd1);
    waitDone(-1, sweepCycles);
    checkOutput("good_latency",  32'(sweepCycles + 4), 32'd64);
    checkOutput("good_busy",     32'(busy),          32'd0);
    checkOutput("good_pass",     32'(pass),          32'd1);
    checkOutput("good_errs",     32'(err_count),     32'd0);
    checkOutput("good_captured", 32'(captured),      32'hA5A5);
    checkOutput("good_vld",      32'(first_err_vld), 32'd0);

    // Single wrong minterm; start from DONE clears results first.
    fMode = 1;
    applyStimulus(1'b0);
    checkOutput("restart_done", 32'(done),      32'd0);
    checkOutput("restart_busy", 32'(busy),      32'd1);
    checkOutput("restart_cap",  32'(captured),  32'd0);
    checkOutput("restart_errs", 32'(err_count), 32'd0);
    waitDone(-1, sweepCycles);
    checkOutput("one_latency",  32'(sweepCycles), 32'd64);
    checkOutput("one_errs",     32'(err_count),     32'd1);
    checkOutput("one_first",    32'(first_err),     32'd5);
    checkOutput("one_vld",      32'(first_err_vld), 32'd1);
    checkOutput("one_pass",     32'(pass),          32'd0);
    checkOutput("one_captured", 32'(captured),      32'hA585);

    // Output stuck at 0.
    fMode = 2;
    applyStimulus(1'b0);
    waitDone(-1, sweepCycles);
`ifdef KMAP_STOP_ON_ERR_EN
    checkOutput("stuck_latency", 32'(sweepCycles), 32'd4);
    checkOutput("stuck_errs",    32'(err_count),   32'd1);
`else
    checkOutput("stuck_latency", 32'(sweepCycles), 32'd64);
    checkOutput("stuck_errs",    32'(err_count),   32'd8);
`endif
    checkOutput("stuck_first",    32'(first_err),     32'd0);
    checkOutput("stuck_vld",      32'(first_err_vld), 32'd1);
    checkOutput("stuck_pass",     32'(pass),          32'd0);
    checkOutput("stuck_captured", 32'(captured),      32'h0000);

    // Reset in the middle of a sweep, then a clean sweep from abcd=0.
    fMode = 0;
    applyStimulus(1'b0);
    waitAbcd(4'd7);
    checkOutput("mid_abcd7", 32'(abcd), 32'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkReset("midreset");
    rst_n = 1'b1;
    applyStimulus(1'b0);
    checkOutput("after_rst_abcd", 32'(abcd), 32'd0);
    checkOutput("after_rst_busy", 32'(busy), 32'd1);
    waitDone(-1, sweepCycles);
    checkOutput("after_rst_latency", 32'(sweepCycles), 32'd64);
    checkOutput("after_rst_pass",    32'(pass),        32'd1);

    // Start pulse while busy must not disturb the sweep.
    applyStimulus(1'b0);
    waitDone(3, sweepCycles);
    checkOutput("ign_latency",  32'(sweepCycles), 32'd64);
    checkOutput("ign_pass",     32'(pass),        32'd1);
    checkOutput("ign_captured", 32'(captured),    32'hA5A5);

    // Start held high: back-to-back sweeps with a single done cycle.
    applyStimulus(1'b1);
    waitDone(-1, sweepCycles);
    start = 1'b1;
    checkOutput("b2b_latency1", 32'(sweepCycles), 32'd64);
    @(posedge clk);
    #1;
    checkOutput("b2b_done_gap", 32'(done), 32'd0);
    checkOutput("b2b_busy_gap", 32'(busy), 32'd1);
    sweepCycles = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      sweepCycles++;
      if (done) break;
    end
    start = 1'b0;
    checkOutput("b2b_latency2", 32'(sweepCycles), 32'd64);
    checkOutput("b2b_pass",     32'(pass),        32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b_hold_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
